queue_msg_downsizer: RTL and testbench

// - Read-domain stage directly downstream of the bisynchronous normal queue: consumes wide

---
 rtl/queue_msg_downsizer_pkg.sv | 10 +
 rtl/queue_msg_downsizer_if.sv | 18 +
 rtl/queue_msg_downsizer_beat_ctr.sv | 21 ++
 rtl/queue_msg_downsizer.sv | 81 ++++++++
 tb/tb_queue_msg_downsizer.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/queue_msg_downsizer_pkg.sv
// queue_msg_downsizer_pkg: shared FSM state type and geometry helpers for the queue downsizer
package queue_downsizer_pkg;
    typedef enum logic {IDLE, SEND} state_t;
    function automatic int f_ratio(input int in_w, input int out_w);
        return in_w / out_w;
    endfunction
    function automatic int f_beat_bits(input int ratio);
        return (ratio < 2) ? 1 : $clog2(ratio);
    endfunction
endpackage

// File: rtl/queue_msg_downsizer_if.sv
// queue_msg_downsizer_if: wide val/rdy input link and narrow val/rdy/last output link
//   in_val/in_rdy/in_msg      : wide message from queue read port
//   out_val/out_rdy/out_msg   : narrow beat stream, out_last marks final beat
//   modport slave  : the downsizer; modport master : queue + consumer side
interface queue_msg_downsizer_if #(
    parameter int p_in_width  = 32,
    parameter int p_out_width = 8
);
    logic                   in_val;
    logic                   in_rdy;
    logic [p_in_width-1:0]  in_msg;
    logic                   out_val;
    logic                   out_rdy;
    logic [p_out_width-1:0] out_msg;
    logic                   out_last;
    modport slave  (input in_val, in_msg, out_rdy, output in_rdy, out_val, out_msg, out_last);
    modport master (output in_val, in_msg, out_rdy, input in_rdy, out_val, out_msg, out_last);
endinterface

// File: rtl/queue_msg_downsizer_beat_ctr.sv
// queue_downsizer_beat_ctr: beat index counter with clear priority over increment
//   clk, reset_n (async active-low), i_clr, i_inc -> o_count, o_is_last (count == p_ratio-1)
module queue_downsizer_beat_ctr #(
    parameter int p_ratio = 4,
    parameter int p_bits  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_clr,
    input  logic              i_inc,
    output logic [p_bits-1:0] o_count,
    output logic              o_is_last
);
    logic [p_bits-1:0] r_count;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_count <= '0;
        else          r_count <= i_clr ? '0 : i_inc ? r_count + 1'b1 : r_count;
    end
    assign o_count   = r_count;
    assign o_is_last = r_count == p_bits'(p_ratio - 1);
endmodule

// File: rtl/queue_msg_downsizer.sv
// queue_msg_downsizer: splits wide queue messages into narrow beats with zero-bubble reload
//   clk, reset_n (async active-low), q_if (slave modport of queue_msg_downsizer_if)
//   Build option QUEUE_DOWNSIZER_MSB_FIRST_EN: emit most-significant slice first
module queue_msg_downsizer
    import queue_downsizer_pkg::*;
#(
    parameter int p_in_width  = 32,
    parameter int p_out_width = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    queue_msg_downsizer_if.slave  q_if
);
    localparam int c_ratio     = f_ratio(p_in_width, p_out_width);
    localparam int c_beat_bits = f_beat_bits(c_ratio);

    if ((p_in_width % p_out_width) != 0 || c_ratio < 2) begin : g_bad_cfg
        $error("queue_msg_downsizer: p_in_width must be a multiple >= 2 of p_out_width");
    end

    state_t                                r_state;
    state_t                                w_next;
    logic [p_in_width-1:0]                 r_hold;
    logic [c_ratio-1:0][p_out_width-1:0]   w_slices;
    logic [c_beat_bits-1:0]                w_beat;
    logic [c_beat_bits-1:0]                w_idx;
    logic                                  w_is_last;
    logic                                  w_out_val;
    logic                                  w_out_go;
    logic                                  w_in_rdy;
    logic                                  w_in_go;
    logic                                  w_clr;
    logic                                  w_inc;

    // Reload happens in the same cycle the last beat leaves, so in_rdy depends on out_rdy
    always_comb begin
        w_next    = r_state;
        w_out_val = r_state == SEND;
        w_out_go  = w_out_val & q_if.out_rdy;
        w_in_rdy  = reset_n & ((r_state == IDLE) | (w_out_go & w_is_last));
        w_in_go   = q_if.in_val & w_in_rdy;
        w_clr     = w_in_go | (w_out_go & w_is_last);
        w_inc     = w_out_go & ~w_is_last;
        w_next    = (r_state == IDLE) ? (w_in_go ? SEND : IDLE)
                  : (w_out_go & w_is_last & ~w_in_go) ? IDLE : SEND;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     r_hold <= '0;
        else if (w_in_go) r_hold <= q_if.in_msg;
    end

    queue_downsizer_beat_ctr #(
        .p_ratio (c_ratio),
        .p_bits  (c_beat_bits)
    ) u_beat_ctr (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_clr     (w_clr),
        .i_inc     (w_inc),
        .o_count   (w_beat),
        .o_is_last (w_is_last)
    );

    assign w_slices = r_hold;
`ifdef QUEUE_DOWNSIZER_MSB_FIRST_EN
    assign w_idx = c_beat_bits'(c_ratio - 1) - w_beat;
`else
    assign w_idx = w_beat;
`endif

    assign q_if.in_rdy   = w_in_rdy;
    assign q_if.out_val  = w_out_val;
    assign q_if.out_last = w_out_val & w_is_last;
    assign q_if.out_msg  = w_out_val ? w_slices[w_idx] : '0;
endmodule

// File: tb/tb_queue_msg_downsizer.sv
// tb_queue_msg_downsizer: table-driven vectors, directed corner sequences and a beat scoreboard
module tb_queue_msg_downsizer;
    typedef struct {
        logic [31:0]      msg;
        int               stall;
        logic [0:3][7:0]  exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    logic [8:0] sb[$];
    vec_t vecs[4];
    vec_t post;

    always #5 clk = ~clk;

    queue_msg_downsizer_if #(.p_in_width(32), .p_out_width(8)) ifc ();
    queue_msg_downsizer_if #(.p_in_width(16), .p_out_width(8)) if2 ();

    queue_msg_downsizer #(.p_in_width(32), .p_out_width(8)) u_dut (
        .clk(clk), .reset_n(reset_n), .q_if(ifc)
    );
    queue_msg_downsizer #(.p_in_width(16), .p_out_width(8)) u_r2 (
        .clk(clk), .reset_n(reset_n), .q_if(if2)
    );

    function automatic int ord(input int i, input int n);
`ifdef QUEUE_DOWNSIZER_MSB_FIRST_EN
        return n - 1 - i;
`else
        return i;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every accepted message pushes its beats in emission order
    always @(negedge clk) begin
        if (reset_n) begin
            if (ifc.out_val && ifc.out_rdy) begin
                if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
                else begin
                    logic [8:0] e;
                    e = sb.pop_front();
                    chk("sb_msg", {24'd0, ifc.out_msg}, {24'd0, e[7:0]});
                    chk("sb_last", {31'd0, ifc.out_last}, {31'd0, e[8]});
                end
            end
            if (ifc.in_val && ifc.in_rdy)
                for (int i = 0; i < 4; i++)
                    sb.push_back({i == 3, ifc.in_msg[8*ord(i, 4) +: 8]});
        end
    end

    task automatic run_vec(input vec_t v);
        int t = 0;
        ifc.in_val = 1'b1;
        ifc.in_msg = v.msg;
        ifc.out_rdy = 1'b1;
        @(negedge clk);
        while (!ifc.in_rdy && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("vec_accept", {31'd0, ifc.in_rdy}, 32'd1);
        @(posedge clk); #1;
        ifc.in_val = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 1 && v.stall > 0) begin
                ifc.out_rdy = 1'b0;
                for (int s = 0; s < v.stall; s++) begin
                    @(negedge clk);
                    chk("stall_msg", {24'd0, ifc.out_msg}, {24'd0, v.exp[ord(1, 4)]});
                    chk("stall_val", {31'd0, ifc.out_val}, 32'd1);
                    chk("stall_in_rdy", {31'd0, ifc.in_rdy}, 32'd0);
                    @(posedge clk); #1;
                end
                ifc.out_rdy = 1'b1;
            end
            @(negedge clk);
            chk("vec_val", {31'd0, ifc.out_val}, 32'd1);
            chk("vec_msg", {24'd0, ifc.out_msg}, {24'd0, v.exp[ord(i, 4)]});
            chk("vec_last", {31'd0, ifc.out_last}, {31'd0, i == 3});
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("vec_idle", {31'd0, ifc.out_val}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [0:3][7:0] e1;
        logic [0:1][7:0] e2;
        logic go;
        vecs[0] = '{msg: 32'hDDCCBBAA, stall: 3, exp: {8'hAA, 8'hBB, 8'hCC, 8'hDD}};
        vecs[1] = '{msg: 32'h12345678, stall: 0, exp: {8'h78, 8'h56, 8'h34, 8'h12}};
        vecs[2] = '{msg: 32'hA5A5F00F, stall: 1, exp: {8'h0F, 8'hF0, 8'hA5, 8'hA5}};
        vecs[3] = '{msg: 32'h00FF00FF, stall: 2, exp: {8'hFF, 8'h00, 8'hFF, 8'h00}};
        post    = '{msg: 32'h44332211, stall: 0, exp: {8'h11, 8'h22, 8'h33, 8'h44}};
        e1 = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
        e2 = {8'hEF, 8'hBE};
        reset_n = 1'b0;
        ifc.in_val = 1'b0; ifc.in_msg = '0; ifc.out_rdy = 1'b1;
        if2.in_val = 1'b0; if2.in_msg = '0; if2.out_rdy = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_val", {31'd0, ifc.out_val}, 32'd0);
        chk("rst_in_rdy", {31'd0, ifc.in_rdy}, 32'd0);
        chk("rst_out_msg", {24'd0, ifc.out_msg}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("rel_in_rdy", {31'd0, ifc.in_rdy}, 32'd1);
        chk("rel_out_val", {31'd0, ifc.out_val}, 32'd0);
        @(posedge clk); #1;
        // single message: first beat the cycle after acceptance, idle right after the last
        ifc.in_val = 1'b1;
        ifc.in_msg = 32'hDDCCBBAA;
        @(negedge clk);
        chk("single_accept", {31'd0, ifc.in_rdy}, 32'd1);
        @(posedge clk); #1;
        ifc.in_val = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("single_val", {31'd0, ifc.out_val}, 32'd1);
            chk("single_msg", {24'd0, ifc.out_msg}, {24'd0, e1[ord(i, 4)]});
            chk("single_last", {31'd0, ifc.out_last}, {31'd0, i == 3});
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("single_idle", {31'd0, ifc.out_val}, 32'd0);
        @(posedge clk); #1;
        // back-to-back: eight beats, no bubble, in_rdy only in IDLE and on last beats
        ifc.in_val = 1'b1;
        ifc.in_msg = 32'h03020100;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            chk("b2b_in_rdy", {31'd0, ifc.in_rdy}, {31'd0, c == 0 || c == 4 || c == 8});
            chk("b2b_val", {31'd0, ifc.out_val}, {31'd0, c != 0});
            if (c != 0)
                chk("b2b_msg", {24'd0, ifc.out_msg}, 32'(4 * ((c - 1) / 4) + ord((c - 1) % 4, 4)));
            go = ifc.in_val & ifc.in_rdy;
            @(posedge clk); #1;
            if (go) begin
                if (ifc.in_msg == 32'h03020100) ifc.in_msg = 32'h07060504;
                else ifc.in_val = 1'b0;
            end
        end
        @(negedge clk);
        chk("b2b_idle", {31'd0, ifc.out_val}, 32'd0);
        @(posedge clk); #1;
        for (int v = 0; v < 4; v++) run_vec(vecs[v]);
        // reset after beat BB is accepted: output drops at once, remaining beats discarded
        ifc.in_val = 1'b1;
        ifc.in_msg = 32'hDDCCBBAA;
        @(negedge clk);
        chk("mid_accept", {31'd0, ifc.in_rdy}, 32'd1);
        @(posedge clk); #1;
        ifc.in_val = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        reset_n = 1'b0;
        sb.delete();
        #1;
        chk("mid_out_val", {31'd0, ifc.out_val}, 32'd0);
        chk("mid_out_msg", {24'd0, ifc.out_msg}, 32'd0);
        chk("mid_in_rdy", {31'd0, ifc.in_rdy}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        run_vec(post);
        // ratio-2 instance
        if2.in_val = 1'b1;
        if2.in_msg = 16'hBEEF;
        @(negedge clk);
        chk("r2_accept", {31'd0, if2.in_rdy}, 32'd1);
        @(posedge clk); #1;
        if2.in_val = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("r2_val", {31'd0, if2.out_val}, 32'd1);
            chk("r2_msg", {24'd0, if2.out_msg}, {24'd0, e2[ord(i, 2)]});
            chk("r2_last", {31'd0, if2.out_last}, {31'd0, i == 1});
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("r2_idle", {31'd0, if2.out_val}, 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
